// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for a shared decoded resource (e.g. a 5-to-32 select decoder).
// Registered grant index/valid/one-hot outputs with hold-time limiting and a one-cycle turnaround.
module rr_decode_arbiter #(
  parameter int unsigned N_REQ    = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              done,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [N_REQ-1:0]  gnt_onehot,
  output logic              timeout
);

  localparam int unsigned SCAN_W    = IDX_W + 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [CNT_W-1:0]    hold_cnt;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [SCAN_W-1:0]   scan_pos;
  logic                rel_req;
  logic                rel_hold;
  logic                tenure_end;

  // First requester at or after ptr, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_pos = {1'b0, ptr} + SCAN_W'(k);
      if (scan_pos >= SCAN_W'(N_REQ)) begin
        scan_pos = scan_pos - SCAN_W'(N_REQ);
      end
      if (!win_found && req[scan_pos[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_pos[IDX_W-1:0];
      end
    end
  end

  // Tenure release conditions while in GRANT.
  always_comb begin
    rel_req    = !req[gnt_idx];
    rel_hold   = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(HOLD_LAST));
    tenure_end = rel_req || done || rel_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (win_found) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= win_idx;
            gnt_onehot <= N_REQ'(1) << win_idx;
            hold_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + CNT_W'(1);
          if (tenure_end) begin
            state      <= GAP;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            ptr        <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
            // Flag only a release forced purely by the hold limit.
            timeout    <= rel_hold && !rel_req && !done;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: the driver queues expected tenures,
// a negedge monitor pops and checks them as grants appear on the outputs.
module tb_rr_decode_arbiter;

  localparam int unsigned N = 32;
  localparam int unsigned W = 5;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic          gnt_valid;
  logic [W-1:0]  gnt_idx;
  logic [N-1:0]  gnt_onehot;
  logic          timeout;

  rr_decode_arbiter #(
    .N_REQ(N), .IDX_W(W), .MAX_HOLD(16), .CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
    .gnt_onehot(gnt_onehot), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // len 0 / gap 0 mean "not checked" for that tenure.
  typedef struct {
    int idx;
    int len;
    bit to;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_tenure(input int idx, input int len, input bit to, input int gap);
    exp_t e;
    e.idx = idx; e.len = len; e.to = to; e.gap = gap;
    sb.push_back(e);
  endtask

  // Returns in cycle 1 of the next tenure (just after gnt_valid rises).
  task automatic wait_grant();
    logic prev;
    bit   got;
    prev = gnt_valid;
    got  = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(posedge clk); #1;
      if (gnt_valid && !prev) got = 1'b1;
      prev = gnt_valid;
    end
    check("grant_wait", 64'(got), 64'd1);
  endtask

  // Called in tenure cycle 1: pulse done in cycle n with req=done_req, then req=after_req.
  task automatic tenure(input int n, input logic [N-1:0] done_req, input logic [N-1:0] after_req);
    repeat (n - 1) begin @(posedge clk); #1; end
    done = 1'b1;
    req  = done_req;
    @(posedge clk); #1;
    done = 1'b0;
    req  = after_req;
  endtask

  // Monitor: per-cycle invariants plus scoreboard compare on grant edges.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_v   = 1'b0;
  bit   exp_to;
  bit   falling;
  int   run_len  = 0;
  int   gap_len  = 0;
  logic [N-1:0] inv_exp;

  initial begin
    forever begin
      @(negedge clk);
      inv_exp = gnt_valid ? (N'(1) << gnt_idx) : '0;
      check("onehot_invariant", 64'(gnt_onehot), 64'(inv_exp));
      falling = prev_v && !gnt_valid;
      exp_to  = 1'b0;
      if (gnt_valid && !prev_v) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", 64'(gnt_idx), 64'hFFFF);
          have_cur = 1'b0;
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check("grant_idx", 64'(gnt_idx), 64'(cur.idx));
          check("grant_onehot", 64'(gnt_onehot), 64'(N'(1) << cur.idx));
          if (cur.gap != 0) check("gap_len", 64'(gap_len), 64'(cur.gap));
        end
        run_len = 1;
      end else if (gnt_valid) begin
        run_len++;
      end
      if (falling) begin
        if (have_cur && cur.len != 0) check("tenure_len", 64'(run_len), 64'(cur.len));
        exp_to  = have_cur && cur.to;
        gap_len = 1;
      end else if (!gnt_valid) begin
        gap_len++;
      end
      check("timeout", 64'(timeout), 64'(exp_to));
      prev_v = gnt_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    done  = 1'b0;
    req   = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt_valid", 64'(gnt_valid), 64'd0);
    check("rst_gnt_idx", 64'(gnt_idx), 64'd0);
    check("rst_gnt_onehot", 64'(gnt_onehot), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // First arbitration after reset starts at ptr=0; then rotation between 3 and 5.
    expect_tenure(0, 1, 1'b0, 0);
    expect_tenure(3, 2, 1'b0, 1);
    expect_tenure(5, 2, 1'b0, 1);
    expect_tenure(3, 2, 1'b0, 1);
    expect_tenure(5, 2, 1'b0, 1);
    rst_n = 1'b1;
    wait_grant();
    tenure(1, '1, N'(32'h28));
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      tenure(2, N'(32'h28), (i == 3) ? '0 : N'(32'h28));
    end

    // Reset while idle to bring ptr back to 0, then full wrap with all requesting.
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 33; i++) expect_tenure(i % 32, 2, 1'b0, (i == 0) ? 0 : 1);
    rst_n = 1'b1;
    req   = '1;
    for (int i = 0; i < 33; i++) begin
      wait_grant();
      tenure(2, '1, (i == 32) ? '0 : '1);
    end

    // Hold limit on a lone requester, then simultaneous done/drop at the last cycle.
    @(posedge clk); #1;
    expect_tenure(7, 16, 1'b1, 0);
    expect_tenure(7, 16, 1'b0, 1);
    expect_tenure(9, 1, 1'b0, 1);
    req = N'(1) << 7;
    wait_grant();
    wait_grant();
    tenure(16, '0, (N'(1) << 7) | (N'(1) << 9));
    wait_grant();
    tenure(1, '0, '0);

    // Asynchronous reset in the middle of a tenure on index 12.
    @(posedge clk); #1;
    expect_tenure(12, 0, 1'b0, 0);
    req = N'(1) << 12;
    wait_grant();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_gnt_valid", 64'(gnt_valid), 64'd0);
    check("async_gnt_onehot", 64'(gnt_onehot), 64'd0);
    check("async_timeout", 64'(timeout), 64'd0);
    check("async_gnt_idx", 64'(gnt_idx), 64'd0);
    req = (N'(1) << 12) | (N'(1) << 20);
    expect_tenure(12, 1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_grant();
    tenure(1, '0, '0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
